// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU-control decode
// and load-use hazard detection for the 32-bit ALU.
module id_ex_stage #(
   parameter int W  = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [W-1:0]  id_rs_data,
   input  logic [W-1:0]  id_rt_data,
   input  logic [W-1:0]  id_imm,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [4:0]    id_shamt,
   input  logic [5:0]    id_funct,
   input  logic [1:0]    id_alu_op,
   input  logic          id_alu_src,
   input  logic          id_reg_dst,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          id_mem_to_reg,
   input  logic          exmem_reg_write,
   input  logic [RW-1:0] exmem_rd,
   input  logic [W-1:0]  exmem_result,
   input  logic          memwb_reg_write,
   input  logic [RW-1:0] memwb_rd,
   input  logic [W-1:0]  memwb_result,
   output logic [5:0]    alu_signal,
   output logic [W-1:0]  alu_data_a,
   output logic [W-1:0]  alu_data_b,
   output logic [4:0]    ex_shamt,
   output logic [W-1:0]  ex_store_data,
   output logic [RW-1:0] ex_dest,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          ex_mem_to_reg,
   output logic          ex_valid,
   output logic          ex_illegal,
   output logic          load_use_stall
);

   typedef struct packed {
      logic          valid;
      logic [W-1:0]  rs_data;
      logic [W-1:0]  rt_data;
      logic [W-1:0]  imm;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] dest;
      logic [4:0]    shamt;
      logic [5:0]    funct;
      logic [1:0]    alu_op;
      logic          alu_src;
      logic          reg_write;
      logic          mem_read;
      logic          mem_write;
      logic          mem_to_reg;
   } id_ex_t;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_SRL = 6'b000010;

   id_ex_t ex_q;
   id_ex_t id_d;

   // Invalid ID slots still carry data, but never control or a destination
   always_comb begin
      id_d         = '0;
      id_d.valid   = id_valid;
      id_d.rs_data = id_rs_data;
      id_d.rt_data = id_rt_data;
      id_d.imm     = id_imm;
      id_d.rs      = id_rs;
      id_d.rt      = id_rt;
      id_d.shamt   = id_shamt;
      id_d.funct   = id_funct;
      id_d.alu_op  = id_alu_op;
      id_d.alu_src = id_alu_src;
      if (id_valid) begin
         id_d.dest       = id_reg_dst ? id_rd : id_rt;
         id_d.reg_write  = id_reg_write;
         id_d.mem_read   = id_mem_read;
         id_d.mem_write  = id_mem_write;
         id_d.mem_to_reg = id_mem_to_reg;
      end
   end

   assign load_use_stall = ex_q.valid & ex_q.mem_read
                         & (ex_q.dest != '0) & id_valid
                         & ((ex_q.dest == id_rs) | (ex_q.dest == id_rt));

   always_ff @(posedge clk) begin
      if (Reset)
         ex_q <= '0;
      else if (flush)
         ex_q <= '0;
      else if (!stall)
         ex_q <= load_use_stall ? '0 : id_d;
   end

   logic ex_hit_a, wb_hit_a, ex_hit_b, wb_hit_b;
   logic [W-1:0] fwd_a, fwd_b;

   assign ex_hit_a = exmem_reg_write & (exmem_rd != '0)
                   & (exmem_rd == ex_q.rs);
   assign wb_hit_a = memwb_reg_write & (memwb_rd != '0)
                   & (memwb_rd == ex_q.rs);
   assign ex_hit_b = exmem_reg_write & (exmem_rd != '0)
                   & (exmem_rd == ex_q.rt);
   assign wb_hit_b = memwb_reg_write & (memwb_rd != '0)
                   & (memwb_rd == ex_q.rt);

   // EX/MEM is the younger result, so it wins over MEM/WB
   always_comb begin
      fwd_a = ex_q.rs_data;
      priority case (1'b1)
         ex_hit_a: fwd_a = exmem_result;
         wb_hit_a: fwd_a = memwb_result;
         default:  fwd_a = ex_q.rs_data;
      endcase
   end

   always_comb begin
      fwd_b = ex_q.rt_data;
      priority case (1'b1)
         ex_hit_b: fwd_b = exmem_result;
         wb_hit_b: fwd_b = memwb_result;
         default:  fwd_b = ex_q.rt_data;
      endcase
   end

   logic funct_ok;

   assign funct_ok = (ex_q.funct == F_AND) | (ex_q.funct == F_OR)
                   | (ex_q.funct == F_ADD) | (ex_q.funct == F_SUB)
                   | (ex_q.funct == F_SLT) | (ex_q.funct == F_SRL);

   always_comb begin
      alu_signal = F_ADD;
      ex_illegal = 1'b0;
      case (ex_q.alu_op)
         2'b00: alu_signal = F_ADD;
         2'b01: alu_signal = F_SUB;
         2'b11: alu_signal = F_OR;
         default: begin
            alu_signal = funct_ok ? ex_q.funct : F_ADD;
            ex_illegal = ex_q.valid & ~funct_ok;
         end
      endcase
   end

   assign alu_data_a    = fwd_a;
   assign alu_data_b    = ex_q.alu_src ? ex_q.imm : fwd_b;
   assign ex_store_data = fwd_b;
   assign ex_shamt      = ex_q.shamt;
   assign ex_dest       = ex_q.dest;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_mem_to_reg = ex_q.mem_to_reg;
   assign ex_valid      = ex_q.valid;

endmodule
